// File: rtl/clint_axi_initiator.sv
// Single-outstanding AXI4 master that turns a command/response handshake into one-beat 64-bit CLINT accesses.
// Optional response timeout with late-beat drain is enabled by defining CLINT_INIT_TIMEOUT_EN.
module clint_axi_initiator #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          timeout_o,

    output logic [AXI_ID_WIDTH-1:0]       m_axi_clint_awid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_clint_awaddr,
    output logic [7:0]                    m_axi_clint_awlen,
    output logic [2:0]                    m_axi_clint_awsize,
    output logic [1:0]                    m_axi_clint_awburst,
    output logic                          m_axi_clint_awlock,
    output logic [3:0]                    m_axi_clint_awcache,
    output logic [2:0]                    m_axi_clint_awprot,
    output logic [3:0]                    m_axi_clint_awqos,
    output logic [3:0]                    m_axi_clint_awregion,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_clint_awuser,
    output logic                          m_axi_clint_awvalid,
    input  logic                          m_axi_clint_awready,

    output logic [AXI_DATA_WIDTH-1:0]     m_axi_clint_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_clint_wstrb,
    output logic                          m_axi_clint_wlast,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_clint_wuser,
    output logic                          m_axi_clint_wvalid,
    input  logic                          m_axi_clint_wready,

    input  logic [AXI_ID_WIDTH-1:0]       m_axi_clint_bid,
    input  logic [1:0]                    m_axi_clint_bresp,
    input  logic [AXI_USER_WIDTH-1:0]     m_axi_clint_buser,
    input  logic                          m_axi_clint_bvalid,
    output logic                          m_axi_clint_bready,

    output logic [AXI_ID_WIDTH-1:0]       m_axi_clint_arid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_clint_araddr,
    output logic [7:0]                    m_axi_clint_arlen,
    output logic [2:0]                    m_axi_clint_arsize,
    output logic [1:0]                    m_axi_clint_arburst,
    output logic                          m_axi_clint_arlock,
    output logic [3:0]                    m_axi_clint_arcache,
    output logic [2:0]                    m_axi_clint_arprot,
    output logic [3:0]                    m_axi_clint_arqos,
    output logic [3:0]                    m_axi_clint_arregion,
    output logic [AXI_USER_WIDTH-1:0]     m_axi_clint_aruser,
    output logic                          m_axi_clint_arvalid,
    input  logic                          m_axi_clint_arready,

    input  logic [AXI_ID_WIDTH-1:0]       m_axi_clint_rid,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_clint_rdata,
    input  logic [1:0]                    m_axi_clint_rresp,
    input  logic                          m_axi_clint_rlast,
    input  logic [AXI_USER_WIDTH-1:0]     m_axi_clint_ruser,
    input  logic                          m_axi_clint_rvalid,
    output logic                          m_axi_clint_rready
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // IDLE accept | WR aw/w pending | WAIT_B | RD ar pending | WAIT_R | RSP hold response | DRAIN swallow late beat
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WAIT_B, S_RD, S_WAIT_R, S_RSP, S_DRAIN
    } state_e;

    state_e                        state_q, state_d;
    logic                          cmd_ready_q, cmd_ready_d;
    logic                          awvalid_q, awvalid_d;
    logic                          wvalid_q, wvalid_d;
    logic                          arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                          err_q, err_d;

    logic                          to_expired;
    logic                          to_hit;
    logic                          late_beat;
    logic                          drain_pend;
    logic                          drain_is_rd;
    logic                          drain_wr, drain_rd;

    assign drain_wr = drain_pend & ~drain_is_rd;
    assign drain_rd = drain_pend & drain_is_rd;

    assign m_axi_clint_awid     = '0;
    assign m_axi_clint_awaddr   = addr_q;
    assign m_axi_clint_awlen    = 8'd0;
    assign m_axi_clint_awsize   = 3'd3;
    assign m_axi_clint_awburst  = 2'b01;
    assign m_axi_clint_awlock   = 1'b0;
    assign m_axi_clint_awcache  = 4'd0;
    assign m_axi_clint_awprot   = 3'd0;
    assign m_axi_clint_awqos    = 4'd0;
    assign m_axi_clint_awregion = 4'd0;
    assign m_axi_clint_awuser   = '0;
    assign m_axi_clint_awvalid  = awvalid_q;

    assign m_axi_clint_wdata    = wdata_q;
    assign m_axi_clint_wstrb    = wstrb_q;
    assign m_axi_clint_wlast    = 1'b1;
    assign m_axi_clint_wuser    = '0;
    assign m_axi_clint_wvalid   = wvalid_q;

    assign m_axi_clint_arid     = '0;
    assign m_axi_clint_araddr   = addr_q;
    assign m_axi_clint_arlen    = 8'd0;
    assign m_axi_clint_arsize   = 3'd3;
    assign m_axi_clint_arburst  = 2'b01;
    assign m_axi_clint_arlock   = 1'b0;
    assign m_axi_clint_arcache  = 4'd0;
    assign m_axi_clint_arprot   = 3'd0;
    assign m_axi_clint_arqos    = 4'd0;
    assign m_axi_clint_arregion = 4'd0;
    assign m_axi_clint_aruser   = '0;
    assign m_axi_clint_arvalid  = arvalid_q;

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d            = state_q;
        awvalid_d          = awvalid_q;
        wvalid_d           = wvalid_q;
        arvalid_d          = arvalid_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        wstrb_d            = wstrb_q;
        rdata_d            = rdata_q;
        err_d              = err_q;
        m_axi_clint_bready = 1'b0;
        m_axi_clint_rready = 1'b0;
        rsp_valid_o        = 1'b0;
        to_hit             = 1'b0;
        late_beat          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d  = {cmd_addr_i[AXI_ADDR_WIDTH-1:3], 3'b000};
                    wdata_d = cmd_wdata_i;
                    wstrb_d = cmd_wstrb_i;
                    if (cmd_write_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD;
                    end
                end
            end
            S_WR: begin
                awvalid_d = awvalid_q & ~m_axi_clint_awready;
                wvalid_d  = wvalid_q & ~m_axi_clint_wready;
                if (!awvalid_d && !wvalid_d) state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                m_axi_clint_bready = 1'b1;
                if (m_axi_clint_bvalid) begin
                    rdata_d = '0;
                    err_d   = (m_axi_clint_bresp != 2'b00);
                    state_d = S_RSP;
                end else if (to_expired) begin
                    to_hit  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RD: begin
                arvalid_d = ~m_axi_clint_arready;
                if (m_axi_clint_arready) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                m_axi_clint_rready = 1'b1;
                if (m_axi_clint_rvalid) begin
                    rdata_d = m_axi_clint_rdata;
                    err_d   = (m_axi_clint_rresp != 2'b00) | ~m_axi_clint_rlast;
                    state_d = S_RSP;
                end else if (to_expired) begin
                    to_hit  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid_o        = 1'b1;
                // After a timeout the slave may still answer; swallow it here so DRAIN can be skipped.
                m_axi_clint_bready = drain_wr;
                m_axi_clint_rready = drain_rd;
                late_beat = (drain_wr & m_axi_clint_bvalid) | (drain_rd & m_axi_clint_rvalid);
                if (rsp_ready_i) state_d = (drain_pend && !late_beat) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                m_axi_clint_bready = drain_wr;
                m_axi_clint_rready = drain_rd;
                late_beat = (drain_wr & m_axi_clint_bvalid) | (drain_rd & m_axi_clint_rvalid);
                if (late_beat || !drain_pend) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

`ifdef CLINT_INIT_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        drain_q;
    logic        drain_rd_q;
    logic        timeout_q;

    assign to_expired  = (cnt_q == TO_LAST);
    assign drain_pend  = drain_q;
    assign drain_is_rd = drain_rd_q;
    assign timeout_o   = timeout_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            drain_rd_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_WAIT_B || state_q == S_WAIT_R) ? cnt_q + 16'd1 : 16'd0;
            if (to_hit) begin
                timeout_q  <= 1'b1;
                drain_q    <= 1'b1;
                drain_rd_q <= (state_q == S_WAIT_R);
            end else if (late_beat) begin
                drain_q    <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{m_axi_clint_bid, m_axi_clint_buser, m_axi_clint_rid,
                         m_axi_clint_ruser, cmd_addr_i[2:0]};
`else
    assign to_expired  = 1'b0;
    assign drain_pend  = 1'b0;
    assign drain_is_rd = 1'b0;
    assign timeout_o   = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{m_axi_clint_bid, m_axi_clint_buser, m_axi_clint_rid,
                         m_axi_clint_ruser, cmd_addr_i[2:0], TO_LAST, to_hit, late_beat};
`endif

endmodule

// File: doc/clint_axi_initiator.md
# clint_axi_initiator

Single-outstanding AXI4 master that turns a simple command/response handshake into one-beat 64-bit AXI reads and writes toward the CLINT slave port, e.g. `mtimecmp` and `msip`. It sits on the initiator side of the CLINT crossbar link and is used by boot/debug helper logic to program timer compare and software-interrupt registers without a full core. All AXI channels use burst length 1.

## Interface
- AXI_ID_WIDTH, 6, width of awid/bid/arid/rid
- AXI_ADDR_WIDTH, 64, width of command and AXI addresses
- AXI_DATA_WIDTH, 64, data width; only 64 supported
- AXI_USER_WIDTH, 1, width of awuser/wuser/aruser; driven 0
- TIMEOUT_CYCLES, 1024, response timeout, only meaningful with CLINT_INIT_TIMEOUT_EN; must fit 16 bits
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  AXI_ADDR_WIDTH  byte address
- cmd_wdata_i  in  64  write data
- cmd_wstrb_i  in  8  write byte strobes
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  64  read data; 0 for writes
- rsp_err_o  out  1  SLVERR/DECERR, missing rlast, or timeout
- timeout_o  out  1  sticky timeout flag; cleared only by reset
- m_axi_clint_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  per AXI4 widths  write address
- m_axi_clint_awready  in  1
- m_axi_clint_w{data,strb,last,user,valid}  out  64/8/1/USER/1  write data
- m_axi_clint_wready  in  1
- m_axi_clint_b{id,resp,user,valid}  in  ID/2/USER/1; m_axi_clint_bready out 1
- m_axi_clint_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user,valid}  out  read address
- m_axi_clint_arready  in  1
- m_axi_clint_r{id,data,resp,last,user,valid}  in; m_axi_clint_rready out 1

## Operation
- Constant fields: id=0, len=0, size=3, burst=INCR, lock/cache/prot/qos/region/user=0, wlast=1.
- Addresses are aligned: axaddr = {cmd_addr_i[AW-1:3], 3'b000}.
- FSM states: IDLE, WR (AW and/or W pending), WAIT_B, RD (AR pending), WAIT_R, RSP, DRAIN.
- IDLE: cmd_ready_o=1; on accept, latch the command, go to WR or RD.
- WR: awvalid and wvalid are registered. Each deasserts independently on its own handshake. Go to WAIT_B once both handshakes are done; the same-cycle case is allowed.
- WAIT_B: bready=1; on B handshake, rsp_err = (bresp != OKAY). Go to RSP.
- RD: arvalid=1 until handshake, then WAIT_R.
- WAIT_R: rready=1; on R handshake, capture rdata and set err = (rresp != OKAY) | !rlast. Go to RSP.
- RSP: rsp_valid_o=1 with data/err held stable until rsp_ready_i, then IDLE.
- No new command is accepted outside IDLE.
- cmd_ready_o is high only in IDLE.

## Timing
- Reset values: all valid/ready outputs 0, rsp_rdata_o 0, rsp_err_o 0, timeout_o 0, cmd_ready_o 0.
- After aresetn deasserts, cmd_ready_o rises at the first aclk edge.
- Asserting reset mid-transaction drops all valids immediately and returns the FSM to IDLE. The latched command is discarded.
- Minimum latency, command accepted at edge T:
  - ax/w valid visible in cycle T+1.
  - With ready in T+1 and response valid in T+2, rsp_valid_o is high in cycle T+3.
- Back-to-back: the next command can be accepted the cycle after the rsp handshake.
- Valids never drop before their handshake, per the AXI rule (except under reset).

## Configuration
- Macro: CLINT_INIT_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT_B/WAIT_R and increments every cycle there.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RSP with rsp_err_o=1 and rsp_rdata_o=0, and sets timeout_o.
  - After the rsp handshake it enters DRAIN instead of IDLE. DRAIN keeps the relevant bready/rready high and returns to IDLE on the late beat, which is discarded.
  - A late beat arriving during RSP is absorbed and recorded, so DRAIN is skipped.
- Undefined: no counter, DRAIN is unreachable, timeout_o is tied 0, and WAIT states wait forever.

## Test plan
- Write addr 0x0200_4000, data 0x1234, strb 0xFF, AW/W/B ready immediately -> awaddr 0x0200_4000, wdata 0x1234, rsp_valid at T+3, err=0.
- Read addr 0x0200_BFF8, rdata 0xDEAD_BEEF, rlast=1 -> rsp_rdata 0xDEAD_BEEF, err=0.
- Write with wready arriving 3 cycles before awready -> wvalid drops after its handshake, awvalid holds, exactly one B, err=0.
- Read returning rresp=SLVERR, and separately rlast=0 -> rsp_err=1 in both cases.
- Timeout (macro on, TIMEOUT_CYCLES=8), no bvalid -> rsp_err=1 after 8 cycles in WAIT_B, timeout_o=1. Late bvalid is absorbed and cmd_ready returns.
- aresetn pulsed low while awvalid=1 -> awvalid=0 asynchronously. After release, cmd_ready_o=1 one edge later.
